// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
// Stall masks are bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; a set bit holds that stage.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WDOG_W  = 16;
  localparam int unsigned FCNT_W  = 4;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;

  localparam logic [DATA_W-1:0] EXC_ERET = 32'h0000000e;

  localparam logic [1:0] PC_RUN   = 2'd0;
  localparam logic [1:0] PC_STALL = 2'd1;
  localparam logic [1:0] PC_FLUSH = 2'd2;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic ifetch;
  } stall_req_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush sequencer.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                stallreq_if;
  logic                stallreq_id;
  logic                stallreq_ex;
  logic                stallreq_mem;
  logic [DATA_W-1:0]   excepttype_i;
  logic [DATA_W-1:0]   cp0_epc_i;
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic [DATA_W-1:0]   new_pc;
  logic                busy;
  logic                stall_timeout;
  logic [DATA_W-1:0]   perf_stall_cnt;
  logic [DATA_W-1:0]   perf_flush_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, busy, stall_timeout, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, busy, stall_timeout, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Priority encoder: per-stage stall requests to a 6-bit hold mask, deepest stage wins.
module pipe_ctrl_stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  stall_req_t         req_i,
  output logic [STALL_W-1:0] mask_o
);

  always_comb begin
    mask_o = STALL_NONE;
    if (req_i.mem)         mask_o = STALL_MEM;
    else if (req_i.ex)     mask_o = STALL_EX;
    else if (req_i.id)     mask_o = STALL_ID;
    else if (req_i.ifetch) mask_o = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: merges stall requests, sequences exception/ERET flushes, stall watchdog.
// Optional performance counters are built when the macro PIPE_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [15:0] STALL_MAX    = 16'd1023,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  logic [1:0]          state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [STALL_W-1:0]  req_mask;
  logic [STALL_W-1:0]  stall_c;
  logic                flush_c;
  logic [DATA_W-1:0]   new_pc_c;
  logic                timeout_c;
  logic                exc;
  stall_req_t          req;

  assign req = '{mem: bus.stallreq_mem, ex: bus.stallreq_ex,
                 id: bus.stallreq_id, ifetch: bus.stallreq_if};
  assign exc = (bus.excepttype_i != '0);

  pipe_ctrl_stall_prio_enc u_enc (
    .req_i  (req),
    .mask_o (req_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_RUN;
      fcnt_q  <= '0;
      pc_q    <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next state plus same-cycle stall/flush; an exception outranks every stall request.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pc_d     = pc_q;
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    new_pc_c = '0;
    case (state_q)
      PC_FLUSH: begin
        flush_c  = 1'b1;
        new_pc_c = pc_q;
        if (fcnt_q == '0) state_d = PC_RUN;
        else              fcnt_d  = FCNT_W'(fcnt_q - 4'd1);
      end
      default: begin
        if (exc) begin
          flush_c  = 1'b1;
          new_pc_c = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
          pc_d     = new_pc_c;
          if (FLUSH_CYCLES > 1) begin
            state_d = PC_FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 32'd2);
          end else begin
            state_d = PC_RUN;
          end
        end else begin
          stall_c = req_mask;
          state_d = (req_mask != STALL_NONE) ? PC_STALL : PC_RUN;
        end
      end
    endcase
  end

  // Watchdog counts consecutive stalled cycles and saturates so the pulse fires once.
  always_comb begin
    wdog_d    = '0;
    timeout_c = 1'b0;
    if ((stall_c != STALL_NONE) && !flush_c) begin
      wdog_d    = (wdog_q == STALL_MAX) ? wdog_q : WDOG_W'(wdog_q + 16'd1);
      timeout_c = (wdog_q == WDOG_W'(STALL_MAX - 16'd1));
    end
  end

  assign bus.stall         = rst ? STALL_NONE : stall_c;
  assign bus.flush         = !rst && flush_c;
  assign bus.new_pc        = rst ? '0 : new_pc_c;
  assign bus.busy          = !rst && (state_q != PC_RUN);
  assign bus.stall_timeout = !rst && timeout_c;

`ifdef PIPE_PERF_EN
  logic [DATA_W-1:0] perf_stall_q;
  logic [DATA_W-1:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_c != STALL_NONE)        perf_stall_q <= DATA_W'(perf_stall_q + 32'd1);
      if (exc && (state_q != PC_FLUSH)) perf_flush_q <= DATA_W'(perf_flush_q + 32'd1);
    end
  end

  assign bus.perf_stall_cnt = rst ? '0 : perf_stall_q;
  assign bus.perf_flush_cnt = rst ? '0 : perf_flush_q;
`else
  assign bus.perf_stall_cnt = 32'h0;
  assign bus.perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; dut_a uses defaults, dut_b uses FLUSH_CYCLES=3, STALL_MAX=8.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] exc_t;
  logic [31:0] epc;
  int          total;
  int          bad;

  pipe_ctrl_if ifa ();
  pipe_ctrl_if ifb ();

  assign ifa.stallreq_if  = req_if;
  assign ifa.stallreq_id  = req_id;
  assign ifa.stallreq_ex  = req_ex;
  assign ifa.stallreq_mem = req_mem;
  assign ifa.excepttype_i = exc_t;
  assign ifa.cp0_epc_i    = epc;
  assign ifb.stallreq_if  = req_if;
  assign ifb.stallreq_id  = req_id;
  assign ifb.stallreq_ex  = req_ex;
  assign ifb.stallreq_mem = req_mem;
  assign ifb.excepttype_i = exc_t;
  assign ifb.cp0_epc_i    = epc;

  pipe_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .STALL_MAX    (16'd8),
    .EXC_VECTOR   (32'h00000020)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0;
    exc_t = 32'h0; epc = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; req_mem = 1'b1;
    #2;
    total++; if (ifa.stall !== 6'b000000) begin bad++; $display("FAIL reset_stall got=%b exp=%b", ifa.stall, 6'b000000); end
    total++; if (ifa.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", ifa.flush); end
    total++; if (ifa.busy !== 1'b0 || ifa.new_pc !== 32'h0 || ifa.stall_timeout !== 1'b0)
      begin bad++; $display("FAIL reset_misc busy=%b new_pc=%h to=%b exp=0/0/0", ifa.busy, ifa.new_pc, ifa.stall_timeout); end
    step();
    rst = 1'b0;
    #2;
    total++; if (ifa.stall !== 6'b011111) begin bad++; $display("FAIL post_reset_stall got=%b exp=%b", ifa.stall, 6'b011111); end
    step();
  endtask

  task automatic test_priority();
    do_reset();
    req_id = 1'b1; req_ex = 1'b1;
    #2;
    total++; if (ifa.stall !== 6'b001111) begin bad++; $display("FAIL prio_ex_id got=%b exp=%b", ifa.stall, 6'b001111); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL prio_busy_run got=%b exp=0", ifa.busy); end
    step();
    req_ex = 1'b0;
    #2;
    total++; if (ifa.stall !== 6'b000111) begin bad++; $display("FAIL prio_id got=%b exp=%b", ifa.stall, 6'b000111); end
    total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL prio_busy_stall got=%b exp=1", ifa.busy); end
    step();
    req_id = 1'b0; req_if = 1'b1; req_mem = 1'b1;
    #2;
    total++; if (ifa.stall !== 6'b011111) begin bad++; $display("FAIL prio_mem_if got=%b exp=%b", ifa.stall, 6'b011111); end
    step();
    req_mem = 1'b0;
    #2;
    total++; if (ifa.stall !== 6'b000011) begin bad++; $display("FAIL prio_if got=%b exp=%b", ifa.stall, 6'b000011); end
    step();
    req_if = 1'b0;
    #2;
    total++; if (ifa.stall !== 6'b000000) begin bad++; $display("FAIL prio_none got=%b exp=%b", ifa.stall, 6'b000000); end
    step();
  endtask

  task automatic test_exception();
    do_reset();
    req_mem = 1'b1; exc_t = 32'h00000001; epc = 32'h12345678;
    #2;
    total++; if (ifa.flush !== 1'b1) begin bad++; $display("FAIL exc_flush got=%b exp=1", ifa.flush); end
    total++; if (ifa.stall !== 6'b000000) begin bad++; $display("FAIL exc_stall got=%b exp=%b", ifa.stall, 6'b000000); end
    total++; if (ifa.new_pc !== 32'h00000020) begin bad++; $display("FAIL exc_new_pc got=%h exp=%h", ifa.new_pc, 32'h00000020); end
    step();
    clear_inputs();
    #2;
    total++; if (ifa.flush !== 1'b0 || ifa.busy !== 1'b0) begin bad++; $display("FAIL exc_back_run flush=%b busy=%b exp=0/0", ifa.flush, ifa.busy); end
    total++; if (ifa.new_pc !== 32'h0) begin bad++; $display("FAIL exc_new_pc_idle got=%h exp=0", ifa.new_pc); end
    step();
  endtask

  task automatic test_eret_flush();
    do_reset();
    exc_t = 32'h0000000e; epc = 32'h00400100; req_mem = 1'b1;
    #2;
    total++; if (ifb.flush !== 1'b1 || ifb.new_pc !== 32'h00400100 || ifb.stall !== 6'b0)
      begin bad++; $display("FAIL eret_c1 flush=%b new_pc=%h stall=%b exp=1/00400100/0", ifb.flush, ifb.new_pc, ifb.stall); end
    step();
    exc_t = 32'h00000001; epc = 32'hdeadbeef;
    #2;
    total++; if (ifb.flush !== 1'b1 || ifb.new_pc !== 32'h00400100 || ifb.stall !== 6'b0 || ifb.busy !== 1'b1)
      begin bad++; $display("FAIL eret_c2 flush=%b new_pc=%h stall=%b busy=%b exp=1/00400100/0/1", ifb.flush, ifb.new_pc, ifb.stall, ifb.busy); end
    step();
    clear_inputs();
    #2;
    total++; if (ifb.flush !== 1'b1 || ifb.new_pc !== 32'h00400100)
      begin bad++; $display("FAIL eret_c3 flush=%b new_pc=%h exp=1/00400100", ifb.flush, ifb.new_pc); end
    step();
    #2;
    total++; if (ifb.flush !== 1'b0 || ifb.new_pc !== 32'h0 || ifb.busy !== 1'b0)
      begin bad++; $display("FAIL eret_c4 flush=%b new_pc=%h busy=%b exp=0/0/0", ifb.flush, ifb.new_pc, ifb.busy); end
    step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    exc_t = 32'h00000004;
    step();
    clear_inputs();
    rst = 1'b1;
    #2;
    total++; if (ifb.flush !== 1'b0 || ifb.busy !== 1'b0 || ifb.new_pc !== 32'h0)
      begin bad++; $display("FAIL abort_in_rst flush=%b busy=%b new_pc=%h exp=0/0/0", ifb.flush, ifb.busy, ifb.new_pc); end
    step();
    rst = 1'b0;
    #2;
    total++; if (ifb.flush !== 1'b0 || ifb.busy !== 1'b0)
      begin bad++; $display("FAIL abort_after flush=%b busy=%b exp=0/0", ifb.flush, ifb.busy); end
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    req_ex = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      #2;
      total++; if (ifb.stall_timeout !== (i == 8))
        begin bad++; $display("FAIL wdog_cycle%0d got=%b exp=%b", i, ifb.stall_timeout, (i == 8)); end
      step();
    end
    req_ex = 1'b0;
    #2;
    total++; if (ifb.stall_timeout !== 1'b0) begin bad++; $display("FAIL wdog_release got=%b exp=0", ifb.stall_timeout); end
    step();
  endtask

  task automatic test_perf();
    logic [31:0] exp_s;
    logic [31:0] exp_f;
`ifdef PIPE_PERF_EN
    exp_s = 32'd5; exp_f = 32'd2;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    do_reset();
    req_if = 1'b1;
    for (int i = 0; i < 5; i++) step();
    req_if = 1'b0;
    exc_t = 32'h00000001; step();
    exc_t = 32'h0;        step();
    exc_t = 32'h00000002; step();
    exc_t = 32'h0;
    #2;
    total++; if (ifa.perf_stall_cnt !== exp_s) begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", ifa.perf_stall_cnt, exp_s); end
    total++; if (ifa.perf_flush_cnt !== exp_f) begin bad++; $display("FAIL perf_flush got=%0d exp=%0d", ifa.perf_flush_cnt, exp_f); end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    rst = 1'b1;
    step();
    test_reset();
    test_priority();
    test_exception();
    test_eret_flush();
    test_reset_abort();
    test_watchdog();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
